// File: rtl/spi_flash_pkg.sv
// Shared opcodes, erase-mode encodings and sequencer state for the SPI flash erase engine.
package spi_flash_pkg;

  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_SE   = 8'h20;
  localparam logic [7:0] OP_BE   = 8'hD8;
  localparam logic [7:0] OP_CE   = 8'hC7;

  typedef enum logic [1:0] {
    MODE_SECTOR = 2'b00,
    MODE_BLOCK  = 2'b01,
    MODE_CHIP   = 2'b10,
    MODE_RSVD   = 2'b11
  } erase_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WREN,
    ST_ERASE,
    ST_POLL,
    ST_HOLD,
    ST_GAP,
    ST_FIN
  } state_e;

  function automatic logic [7:0] erase_opcode(input erase_mode_e m);
    case (m)
      MODE_BLOCK: return OP_BE;
      MODE_CHIP:  return OP_CE;
      default:    return OP_SE;
    endcase
  endfunction

endpackage

// File: rtl/spi_byte_shift.sv
// One-byte SPI mode-0 shifter: MSB first, mosi updated on SCK fall, miso sampled on SCK rise.
module spi_byte_shift #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic [7:0] rx_byte,
  output logic       byte_done
);

  localparam int unsigned   DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic          active_q, active_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic          half, rise, fall;

  always_comb begin
    half     = active_q && (div_q == DIV_LAST);
    rise     = half && !sck_q;
    fall     = half && sck_q;
    active_d = active_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    div_d    = div_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    if (active_q) begin
      div_d = half ? '0 : div_q + 1'b1;
    end
    if (rise) begin
      sck_d = 1'b1;
      rx_d  = {rx_q[6:0], miso};
    end
    if (fall) begin
      sck_d = 1'b0;
      if (bit_q == 3'd7) begin
        active_d = 1'b0;
      end else begin
        bit_d  = bit_q + 3'd1;
        mosi_d = tx_q[6];
        tx_d   = {tx_q[6:0], 1'b0};
      end
    end
    // A load on the final falling edge chains the next byte without a gap.
    if (load) begin
      active_d = 1'b1;
      sck_d    = 1'b0;
      div_d    = '0;
      bit_d    = '0;
      tx_d     = tx_byte;
      mosi_d   = tx_byte[7];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
    end else begin
      active_q <= active_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
    end
  end

  assign sck       = sck_q;
  assign mosi      = mosi_q;
  assign rx_byte   = rx_q;
  assign byte_done = active_q && sck_q && (div_q == DIV_LAST) && (bit_q == 3'd7);

endmodule

// File: rtl/spi_flash_erase_ctrl.sv
// SPI flash erase sequencer: WREN, erase command, then RDSR polling until WIP clears or timeout.
module spi_flash_erase_ctrl
  import spi_flash_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned GAP_CYC  = 5,
  parameter logic [31:0] POLL_MAX = 32'd100_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [23:0] addr,
  input  logic        miso,
  output logic        cs_n,
  output logic        sck,
  output logic        mosi,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_e      state_q, state_d, ret_q, ret_d;
  erase_mode_e mode_q, mode_d;
  logic [23:0] addr_q, addr_d;
  logic [1:0]  idx_q, idx_d, idx_nxt;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] poll_q, poll_d;
  logic        cs_n_q, cs_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        fail_q, fail_d;
  logic        sh_load, sh_done;
  logic [7:0]  sh_tx, rx_byte;
  logic [6:0]  unused_status;

  assign unused_status = rx_byte[7:1];

  spi_byte_shift #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .load      (sh_load),
    .tx_byte   (sh_tx),
    .miso      (miso),
    .sck       (sck),
    .mosi      (mosi),
    .rx_byte   (rx_byte),
    .byte_done (sh_done)
  );

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    idx_nxt = idx_q + 2'd1;
    cnt_d   = cnt_q;
    poll_d  = poll_q;
    cs_n_d  = cs_n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    fail_d  = fail_q;
    sh_load = 1'b0;
    sh_tx   = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = erase_mode_e'(mode);
          addr_d = addr;
          if (erase_mode_e'(mode) == MODE_RSVD) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            cs_n_d  = 1'b0;
            busy_d  = 1'b1;
            sh_load = 1'b1;
            sh_tx   = OP_WREN;
            idx_d   = '0;
            poll_d  = '0;
            fail_d  = 1'b0;
            state_d = ST_WREN;
          end
        end
      end
      ST_WREN: begin
        if (sh_done) begin
          cnt_d   = '0;
          ret_d   = ST_ERASE;
          state_d = ST_HOLD;
        end
      end
      ST_ERASE: begin
        if (sh_done) begin
          if (mode_q == MODE_CHIP || idx_q == 2'd3) begin
            cnt_d   = '0;
            ret_d   = ST_POLL;
            state_d = ST_HOLD;
          end else begin
            idx_d   = idx_nxt;
            sh_load = 1'b1;
            case (idx_nxt)
              2'd1:    sh_tx = addr_q[23:16];
              2'd2:    sh_tx = addr_q[15:8];
              default: sh_tx = addr_q[7:0];
            endcase
          end
        end
      end
      ST_POLL: begin
        if (sh_done) begin
          if (idx_q == 2'd0) begin
            idx_d   = 2'd1;
            sh_load = 1'b1;
            sh_tx   = 8'h00;
          end else begin
            // Status byte is complete here, so the verdict is taken before cs_n rises.
            poll_d  = poll_q + 32'd1;
            cnt_d   = '0;
            state_d = ST_HOLD;
            if (!rx_byte[0]) begin
              ret_d  = ST_FIN;
              fail_d = 1'b0;
            end else if (poll_q + 32'd1 >= POLL_MAX) begin
              ret_d  = ST_FIN;
              fail_d = 1'b1;
            end else begin
              ret_d = ST_POLL;
            end
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == 32'(CLK_DIV - 1)) begin
          cs_n_d  = 1'b1;
          cnt_d   = '0;
          state_d = (ret_q == ST_FIN) ? ST_FIN : ST_GAP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == 32'(GAP_CYC - 1)) begin
          cs_n_d  = 1'b0;
          sh_load = 1'b1;
          sh_tx   = (ret_q == ST_ERASE) ? erase_opcode(mode_q) : OP_RDSR;
          idx_d   = '0;
          state_d = ret_q;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        err_d   = fail_q;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      ret_q   <= ST_IDLE;
      mode_q  <= MODE_SECTOR;
      addr_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      poll_q  <= '0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      poll_q  <= poll_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign cs_n = cs_n_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_spi_flash_erase_ctrl.sv
// Three engines (CLK_DIV 2/1/3) share one flash model; a vector table drives erase transactions.
module tb_spi_flash_erase_ctrl;

  typedef struct {
    logic [1:0]  dut;
    logic [1:0]  mode;
    logic [23:0] addr;
    logic [7:0]  exp_op;
    int unsigned wip_polls;
    logic        exp_err;
    int unsigned exp_polls;
  } vec_t;

  logic        sys_clk, sys_rst_n, start, miso;
  logic [1:0]  mode, sel;
  logic [23:0] addr;
  logic [2:0]  start_v, cs_n_v, sck_v, mosi_v, busy_v, done_v, err_v;
  logic        m_cs, m_sck, m_mosi, m_busy, m_done, m_err;

  int unsigned checks = 0, failures = 0;

  int unsigned cyc = 0, t_cs_fall = 0, t_rise = 0, t_fall = 0, t_cs_rise = 0;
  int unsigned bitn = 0, frames = 0, polls_seen = 0, wip_polls = 0, glitches = 0;
  logic        prev_cs = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0;
  logic [7:0]  sh = '0, frame_op = '0, status;
  logic [7:0]  byte_log[$];
  int unsigned len_log[$];
  vec_t        vecs[9];

  assign start_v = {start && sel == 2'd2, start && sel == 2'd1, start && sel == 2'd0};
  assign m_cs    = cs_n_v[sel];
  assign m_sck   = sck_v[sel];
  assign m_mosi  = mosi_v[sel];
  assign m_busy  = busy_v[sel];
  assign m_done  = done_v[sel];
  assign m_err   = err_v[sel];

  spi_flash_erase_ctrl #(.CLK_DIV(2), .GAP_CYC(5), .POLL_MAX(32'd4)) u_dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start_v[0]), .mode(mode), .addr(addr),
    .miso(miso), .cs_n(cs_n_v[0]), .sck(sck_v[0]), .mosi(mosi_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .err(err_v[0]));

  spi_flash_erase_ctrl #(.CLK_DIV(1), .GAP_CYC(3), .POLL_MAX(32'd4)) u_dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start_v[1]), .mode(mode), .addr(addr),
    .miso(miso), .cs_n(cs_n_v[1]), .sck(sck_v[1]), .mosi(mosi_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .err(err_v[1]));

  spi_flash_erase_ctrl #(.CLK_DIV(3), .GAP_CYC(7), .POLL_MAX(32'd4)) u_dut_c (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start_v[2]), .mode(mode), .addr(addr),
    .miso(miso), .cs_n(cs_n_v[2]), .sck(sck_v[2]), .mosi(mosi_v[2]), .busy(busy_v[2]),
    .done(done_v[2]), .err(err_v[2]));

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  function automatic int unsigned div_of(input logic [1:0] s);
    case (s)
      2'd1:    return 1;
      2'd2:    return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int unsigned gap_of(input logic [1:0] s);
    case (s)
      2'd1:    return 3;
      2'd2:    return 7;
      default: return 5;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Flash model and protocol monitor, sampled mid-cycle on the selected engine.
  always @(negedge sys_clk) begin
    cyc++;
    if (!sys_rst_n) begin
      prev_cs  = 1'b1;
      prev_sck = 1'b0;
      bitn     = 0;
      frame_op = '0;
      miso     = 1'b0;
    end else begin
      if (prev_cs && !m_cs) begin
        if (frames > 0) chk("cs_gap", cyc - t_cs_rise, gap_of(sel));
        t_cs_fall = cyc;
        bitn      = 0;
        frame_op  = '0;
      end
      if (!m_cs && !prev_sck && m_sck) begin
        if (bitn == 0) chk("sck_first_rise", cyc - t_cs_fall, div_of(sel));
        else           chk("sck_period", cyc - t_rise, 2 * div_of(sel));
        if (m_mosi !== prev_mosi) glitches++;
        sh     = {sh[6:0], m_mosi};
        bitn++;
        t_rise = cyc;
        if (bitn % 8 == 0) begin
          byte_log.push_back(sh);
          if (bitn == 8) frame_op = sh;
        end
      end
      if (prev_sck && !m_sck) t_fall = cyc;
      if (!prev_cs && m_cs) begin
        chk("cs_hold", cyc - t_fall, div_of(sel));
        if (frame_op == 8'h05) polls_seen++;
        len_log.push_back(bitn / 8);
        frames++;
        t_cs_rise = cyc;
      end
      status = {6'b0, 1'b1, (polls_seen < wip_polls)};
      miso   = (frame_op == 8'h05 && bitn >= 8 && bitn < 16) ? status[15 - bitn] : 1'b0;
      prev_cs   = m_cs;
      prev_sck  = m_sck;
      prev_mosi = m_mosi;
    end
  end

  task automatic clear_logs();
    byte_log.delete();
    len_log.delete();
    frames     = 0;
    polls_seen = 0;
    glitches   = 0;
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned busy_low, mism, n0;
    bit          seen;
    logic [7:0]  exp_q[$];
    sel       = v.dut;
    wip_polls = v.wip_polls;
    @(negedge sys_clk);
    clear_logs();
    mode  = v.mode;
    addr  = v.addr;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    mode  = 2'b11;
    addr  = '0;
    if (v.mode == 2'b11) begin
      chk("rsvd_done_err", {m_done, m_err, m_busy, m_cs}, 4'b1101);
      @(negedge sys_clk);
      chk("rsvd_pulse", {m_done, m_busy}, 2'b00);
      repeat (30) @(negedge sys_clk);
      chk("rsvd_quiet", frames + (m_cs ? 0 : 1), 0);
      return;
    end
    chk("accept", {m_busy, m_cs, m_done}, 3'b100);
    seen     = 0;
    busy_low = 0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge sys_clk);
      if (i == 10) begin
        start = 1'b1;
        mode  = 2'b00;
        addr  = 24'hFFFFFF;
      end else if (i == 11) begin
        start = 1'b0;
      end
      if (m_done) begin
        seen = 1;
        chk("fin_flags", {m_err, m_busy, m_cs}, {v.exp_err, 1'b0, 1'b1});
      end else if (!m_busy) begin
        busy_low++;
      end
    end
    start = 1'b0;
    chk("done_seen", seen, 1);
    chk("busy_span", busy_low, 0);
    @(negedge sys_clk);
    chk("done_pulse", m_done, 0);
    exp_q = {8'h06, v.exp_op};
    if (v.mode != 2'b10) begin
      exp_q.push_back(v.addr[23:16]);
      exp_q.push_back(v.addr[15:8]);
      exp_q.push_back(v.addr[7:0]);
    end
    for (int unsigned p = 0; p < v.exp_polls; p++) begin
      exp_q.push_back(8'h05);
      exp_q.push_back(8'h00);
    end
    chk("byte_count", byte_log.size(), exp_q.size());
    mism = 0;
    for (int i = 0; i < exp_q.size() && i < byte_log.size(); i++)
      if (byte_log[i] !== exp_q[i]) mism++;
    chk("byte_values", mism, 0);
    chk("erase_frame_bytes", (len_log.size() > 1) ? len_log[1] : 0, (v.mode == 2'b10) ? 1 : 4);
    chk("status_reads", polls_seen, v.exp_polls);
    chk("mosi_stable", glitches, 0);
    n0 = frames;
    repeat (40) @(negedge sys_clk);
    chk("one_erase_only", frames, n0);
  endtask

  initial begin
    bit seen;
    sys_rst_n = 1'b1;
    start     = 1'b0;
    mode      = '0;
    addr      = '0;
    sel       = '0;
    vecs[0] = '{2'd0, 2'b00, 24'h123456, 8'h20, 3,   1'b0, 4};
    vecs[1] = '{2'd0, 2'b10, 24'hABCDEF, 8'hC7, 1,   1'b0, 2};
    vecs[2] = '{2'd0, 2'b01, 24'hFF0000, 8'hD8, 0,   1'b0, 1};
    vecs[3] = '{2'd0, 2'b00, 24'h00A5C3, 8'h20, 100, 1'b1, 4};
    vecs[4] = '{2'd0, 2'b11, 24'h123456, 8'h00, 0,   1'b1, 0};
    vecs[5] = '{2'd1, 2'b00, 24'h000FFF, 8'h20, 2,   1'b0, 3};
    vecs[6] = '{2'd2, 2'b01, 24'h7A5A01, 8'hD8, 1,   1'b0, 2};
    vecs[7] = '{2'd2, 2'b10, 24'h000000, 8'hC7, 100, 1'b1, 4};
    vecs[8] = '{2'd1, 2'b11, 24'h000000, 8'h00, 0,   1'b1, 0};
    #3 sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    for (int s = 0; s < 3; s++) begin
      sel = s[1:0];
      #1;
      chk("reset_state", {m_cs, m_sck, m_mosi, m_busy, m_done, m_err}, 6'b100000);
    end
    sel = '0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset in the middle of the erase command frame.
    sel       = 2'd0;
    wip_polls = 3;
    @(negedge sys_clk);
    clear_logs();
    mode  = 2'b00;
    addr  = 24'h0F0F0F;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    seen  = 0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge sys_clk);
      if (frames == 1 && bitn >= 12) seen = 1;
    end
    chk("reach_erase_frame", seen, 1);
    @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1 chk("reset_async", {m_cs, m_sck, m_mosi, m_busy, m_done, m_err}, 6'b100000);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (40) @(negedge sys_clk);
    chk("post_reset_idle", {m_cs, m_busy, m_done}, 3'b100);
    chk("post_reset_frames", frames, 1);

    run_vec(vecs[2]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
